fclk_align: RTL

Parametrised frame-clock alignment controller for the ADC deserialiser path. It runs in the `divclk` domain and watches the deserialised frame-clock word. It issues single-cycle `bitslip` pulses, with a settle gap after each, until the word matches the frame pattern. It then confirms lock over consecutive samples, monitors for loss of lock, and reports lock, failure and slip/loss statistics to the capture logic.

---
 rtl/fclk_align.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fclk_align.sv
// fclk_align: frame-clock alignment controller for the ADC deserialiser path.
// Issues single-cycle bitslip pulses, each followed by a settle gap, until the
// deserialised frame-clock word equals FRAME_PATTERN. It then confirms lock over
// LOCK_COUNT consecutive samples and watches for LOSS_COUNT consecutive misses.
// Optional feature macro: FCLK_ALIGN_RELOCK_EN -- when defined, a loss of lock
// restarts alignment automatically instead of parking in LOST until realign.
`timescale 1ns/1ps

module fclk_align #(
  parameter int                     DESER_WIDTH   = 8,
  parameter logic [DESER_WIDTH-1:0] FRAME_PATTERN = 8'h0F,
  parameter int                     SETTLE_CYCLES = 16,
  parameter int                     LOCK_COUNT    = 4,
  parameter int                     LOSS_COUNT    = 2
) (
  input  logic                               divclk,
  input  logic                               rst,
  input  logic [DESER_WIDTH-1:0]             fclk_deser,
  input  logic                               realign,
  output logic                               bitslip,
  output logic                               locked,
  output logic                               align_fail,
  output logic [$clog2(DESER_WIDTH+1)-1:0]   slip_count,
  output logic [7:0]                         loss_count
);

  localparam int SCW = $clog2(DESER_WIDTH + 1);
  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int LCW = $clog2(LOSS_COUNT + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(DESER_WIDTH);
  localparam logic [SCW-1:0] SLIP_ONE    = SCW'(1);
  localparam logic [MCW-1:0] MATCH_TGT   = MCW'(LOCK_COUNT);
  localparam logic [MCW-1:0] MATCH_ONE   = MCW'(1);
  localparam logic [LCW-1:0] MISS_TGT    = LCW'(LOSS_COUNT);
  localparam logic [LCW-1:0] MISS_ONE    = LCW'(1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
  localparam logic [STW-1:0] SETTLE_ONE  = STW'(1);

  typedef enum logic [2:0] {
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_CONFIRM,
    ST_LOCKED,
    ST_LOST,
    ST_FAIL
  } state_t;

  state_t           state_q,  state_d;
  logic [SCW-1:0]   slip_q,   slip_d;
  logic [MCW-1:0]   match_q,  match_d;
  logic [LCW-1:0]   miss_q,   miss_d;
  logic [STW-1:0]   settle_q, settle_d;
  logic [7:0]       loss_q,   loss_d;
  logic             bitslip_q, locked_q, fail_q;
  logic             bitslip_d, locked_d, fail_d;
  logic             word_ok;

  assign word_ok = (fclk_deser == FRAME_PATTERN);

  // Next-state and counter update; realign overrides everything except loss_count.
  always_comb begin
    // NOTE: every _d starts from its current value so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    miss_d   = miss_q;
    settle_d = settle_q;
    loss_d   = loss_q;

    unique case (state_q)
      ST_CHECK: begin
        if (word_ok) begin
          miss_d  = '0;
          match_d = MATCH_ONE;
          state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CONFIRM;
        end else if (slip_q == SLIP_MAX) begin
          state_d = ST_FAIL;
        end else begin
          // slip_count advances together with the pulse it counts
          state_d  = ST_SLIP;
          slip_d   = slip_q + SLIP_ONE;
          settle_d = '0;
        end
      end

      ST_SLIP: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end

      ST_CONFIRM: begin
        if (word_ok) begin
          match_d = match_q + MATCH_ONE;
          if ((match_q + MATCH_ONE) == MATCH_TGT) state_d = ST_LOCKED;
        end else if (slip_q == SLIP_MAX) begin
          state_d = ST_FAIL;
        end else begin
          state_d  = ST_SLIP;
          slip_d   = slip_q + SLIP_ONE;
          settle_d = '0;
        end
      end

      ST_LOCKED: begin
        if (word_ok) begin
          miss_d = '0;
        end else begin
          miss_d = miss_q + MISS_ONE;
          if ((miss_q + MISS_ONE) == MISS_TGT) begin
            loss_d = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
`ifdef FCLK_ALIGN_RELOCK_EN
            state_d = ST_CHECK;
            slip_d  = '0;
            match_d = '0;
            miss_d  = '0;
`else
            state_d = ST_LOST;
`endif
          end
        end
      end

      ST_LOST, ST_FAIL: state_d = state_q;

      default: state_d = ST_CHECK;
    endcase

    if (realign) begin
      state_d  = ST_CHECK;
      slip_d   = '0;
      match_d  = '0;
      miss_d   = '0;
      settle_d = '0;
    end

    bitslip_d = (state_d == ST_SLIP);
    locked_d  = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAIL);
  end

  // State, counters and registered outputs; reset clears all of them at once.
  always_ff @(posedge divclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CHECK;
      slip_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      settle_q  <= '0;
      loss_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      slip_q    <= slip_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      settle_q  <= settle_d;
      loss_q    <= loss_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign align_fail = fail_q;
  assign slip_count = slip_q;
  assign loss_count = loss_q;

endmodule
